// File: rtl/mult_div_scp.sv
// -----------------------------------------------------------------------------
// mult_div_scp
//
// Iterative multiply/divide unit with the HI/LO architectural registers.
// Multiplies use radix-2 shift-add into a 2*WL accumulator. Divides use
// restoring division, one quotient bit per cycle. Signed operations work on
// operand magnitudes, and the signs are applied in the FIX state.
//
// Sequence: IDLE --START--> RUN (WL-1 cycles) --> FIX --> IDLE.
// The FIX cycle performs the last iteration and writes HI/LO.
//
// Optional build macro:
//   MULT_DIV_ZERO_SKIP_EN - when SRCA or SRCB is zero, go straight from IDLE to
//                           FIX. The results are identical to the full run.
//
// Ports:
//   CLK     in   clock, rising edge
//   RST     in   synchronous active-high reset
//   START   in   start request, sampled only in IDLE
//   OP      in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   SRCA    in   multiplicand / dividend
//   SRCB    in   multiplier / divisor
//   HIWE    in   MTHI write enable (IDLE only)
//   LOWE    in   MTLO write enable (IDLE only)
//   HILOWD  in   MTHI/MTLO write data
//   BUSY    out  operation in flight (RUN or FIX)
//   DONE    out  one-cycle pulse after HI/LO take a new result
//   HI      out  product upper half / remainder
//   LO      out  product lower half / quotient
// -----------------------------------------------------------------------------
module mult_div_scp #(
    parameter int WL = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    input  logic [1:0]    OP,
    input  logic [WL-1:0] SRCA,
    input  logic [WL-1:0] SRCB,
    input  logic          HIWE,
    input  logic          LOWE,
    input  logic [WL-1:0] HILOWD,
    output logic          BUSY,
    output logic          DONE,
    output logic [WL-1:0] HI,
    output logic [WL-1:0] LO
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int            CW       = $clog2(WL + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WL);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [2*WL-1:0] acc_q;      // {partial hi, multiplier / dividend-quotient}
    logic [WL-1:0]   opb_q;      // multiplicand magnitude or divisor magnitude
    logic [WL-1:0]   srca_q;     // raw dividend, needed for the divide-by-zero HI
    logic            is_div_q;
    logic            neg_q;      // negate product / quotient
    logic            neg_rem_q;  // negate remainder (dividend was negative)
    logic            skip_q;
    logic            done_q;
    logic [WL-1:0]   hi_q, lo_q;

    // Operand preparation at START
    logic            sign_a, sign_b;
    logic [WL-1:0]   a_mag, b_mag;
    logic            skip_req;

    assign sign_a = ~OP[0] & SRCA[WL-1];
    assign sign_b = ~OP[0] & SRCB[WL-1];
    // -0x80..0 wraps to itself, which is already the correct unsigned magnitude.
    assign a_mag  = sign_a ? -SRCA : SRCA;
    assign b_mag  = sign_b ? -SRCB : SRCB;

`ifdef MULT_DIV_ZERO_SKIP_EN
    assign skip_req = (SRCA == '0) || (SRCB == '0);
`else
    assign skip_req = 1'b0;
`endif

    // One iteration of the shift-add or restoring-divide step
    logic [WL:0]     mul_sum;
    logic [2*WL-1:0] mul_next;
    logic [WL:0]     div_shl, div_diff;
    logic            div_ge;
    logic [2*WL-1:0] div_next;
    logic [2*WL-1:0] step_acc;

    assign mul_sum  = {1'b0, acc_q[2*WL-1:WL]} + (acc_q[0] ? {1'b0, opb_q} : {(WL+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[WL-1:1]};

    // The partial remainder is always below the divisor, so WL+1 bits hold the shift.
    assign div_shl  = {acc_q[2*WL-1:WL], acc_q[WL-1]};
    assign div_diff = div_shl - {1'b0, opb_q};
    assign div_ge   = ~div_diff[WL];  // no borrow: remainder >= divisor
    assign div_next = {(div_ge ? div_diff[WL-1:0] : div_shl[WL-1:0]), acc_q[WL-2:0], div_ge};

    assign step_acc = is_div_q ? div_next : mul_next;

    // Final result formed in FIX from the last iteration
    logic [2*WL-1:0] prod_fix;
    logic [WL-1:0]   quo_fix, rem_fix;
    logic [WL-1:0]   fin_hi, fin_lo;

    assign prod_fix = neg_q     ? -step_acc : step_acc;
    assign quo_fix  = neg_q     ? -step_acc[WL-1:0] : step_acc[WL-1:0];
    assign rem_fix  = neg_rem_q ? -step_acc[2*WL-1:WL] : step_acc[2*WL-1:WL];

    // Next-state and result selection
    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        fin_hi  = prod_fix[2*WL-1:WL];
        fin_lo  = prod_fix[WL-1:0];

        if (is_div_q && (opb_q == '0)) begin
            fin_hi = srca_q;
            fin_lo = '1;
        end else if (skip_q) begin
            fin_hi = '0;
            fin_lo = '0;
        end else if (is_div_q) begin
            fin_hi = rem_fix;
            fin_lo = quo_fix;
        end

        case (state_q)
            S_IDLE:  if (START) state_d = skip_req ? S_FIX : S_RUN;
            S_RUN:   if (cnt_q == CW'(2)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before the edge.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            srca_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            skip_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= (state_q == S_FIX);
            case (state_q)
                S_IDLE: begin
                    // An MT write in the START cycle lands, and FIX overwrites it later.
                    if (HIWE) hi_q <= HILOWD;
                    if (LOWE) lo_q <= HILOWD;
                    if (START) begin
                        is_div_q  <= OP[1];
                        neg_q     <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        srca_q    <= SRCA;
                        skip_q    <= skip_req;
                        cnt_q     <= CNT_LOAD;
                        if (OP[1]) begin
                            acc_q <= {{WL{1'b0}}, a_mag};
                            opb_q <= b_mag;
                        end else begin
                            acc_q <= {{WL{1'b0}}, b_mag};
                            opb_q <= a_mag;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= step_acc;
                    cnt_q <= cnt_q - CW'(1);
                end
                S_FIX: begin
                    hi_q <= fin_hi;
                    lo_q <= fin_lo;
                end
                default: ;
            endcase
        end
    end

    assign BUSY = (state_q != S_IDLE);
    assign DONE = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
